// File: rtl/obstacle_runner.sv
// obstacle_runner: scrolls a single obstacle toward the player column once per
// game tick. It checks each tick for a collision against the current jump height,
// keeps score and lives, and sequences IDLE / RUN / RECOVER / OVER.
// All outputs are registered and updated from one state machine.
module obstacle_runner #(
  parameter int X_START       = 640,
  parameter int SPEED         = 10,
  parameter int PLAYER_X      = 100,
  parameter int PLAYER_W      = 20,
  parameter int OBS_W         = 20,
  parameter int OBS_H         = 40,
  parameter int LIVES         = 3,
  parameter int RECOVER_TICKS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic [9:0]  jump_h,
  output logic [9:0]  obs_x,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic        hit,
  output logic        running,
  output logic        game_over
);

  localparam int CNT_W = $clog2(RECOVER_TICKS + 1);

  localparam logic [9:0]       X_INIT     = 10'(X_START);
  localparam logic [9:0]       STEP       = 10'(SPEED);
  localparam logic [10:0]      PLAYER_L   = 11'(PLAYER_X);
  localparam logic [10:0]      PLAYER_R   = 11'(PLAYER_X + PLAYER_W);
  localparam logic [10:0]      OBS_WIDTH  = 11'(OBS_W);
  localparam logic [9:0]       CLEAR_H    = 10'(OBS_H);
  localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
  localparam logic [CNT_W-1:0] REC_INIT   = CNT_W'(RECOVER_TICKS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_RECOVER,
    S_OVER
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] rec_cnt;

  logic [10:0] obs_left;
  logic [10:0] obs_right;
  logic        collide;
  logic        wrap;

  // Score counter that sticks at its maximum instead of rolling over.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Overlap test on the pre-update obstacle position; 11-bit sums cannot overflow.
  always_comb begin
    obs_left  = {1'b0, obs_x};
    obs_right = obs_left + OBS_WIDTH;
    collide   = (obs_left < PLAYER_R) && (obs_right > PLAYER_L) && (jump_h < CLEAR_H);
    wrap      = (obs_x < STEP);
  end

  // Game sequencer with registered outputs; hit is a one-clock pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      obs_x     <= X_INIT;
      score     <= 16'd0;
      lives     <= LIVES_INIT;
      rec_cnt   <= '0;
      hit       <= 1'b0;
      running   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      hit <= 1'b0;
      case (state)
        S_IDLE: begin
          // A tick arriving together with start is deliberately not applied.
          if (start) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end

        S_RUN: begin
          if (tick) begin
            if (collide) begin
              hit   <= 1'b1;
              lives <= lives - 2'd1;
              obs_x <= X_INIT;
              if (lives == 2'd1) begin
                state     <= S_OVER;
                running   <= 1'b0;
                game_over <= 1'b1;
              end else begin
                state   <= S_RECOVER;
                rec_cnt <= REC_INIT;
              end
            end else if (wrap) begin
              obs_x <= X_INIT;
              score <= sat_inc(score);
            end else begin
              obs_x <= obs_x - STEP;
            end
          end
        end

        S_RECOVER: begin
          obs_x <= X_INIT;
          if (tick) begin
            rec_cnt <= rec_cnt - 1'b1;
            if (rec_cnt <= 1) begin
              state <= S_RUN;
            end
          end
        end

        S_OVER: begin
          // Restart goes straight to RUN with a fresh game.
          if (start) begin
            state     <= S_RUN;
            obs_x     <= X_INIT;
            score     <= 16'd0;
            lives     <= LIVES_INIT;
            rec_cnt   <= '0;
            running   <= 1'b1;
            game_over <= 1'b0;
          end
        end

        default: begin
          state   <= S_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_runner.sv
// tb_obstacle_runner: directed gameplay scenarios followed by randomized play.
// Every output is compared each step against a behavioural game model.
module tb_obstacle_runner;

  logic        clk;
  logic        reset;
  logic        tick;
  logic        start;
  logic [9:0]  jump_h;
  logic [9:0]  obs_x;
  logic [15:0] score;
  logic [1:0]  lives;
  logic        hit;
  logic        running;
  logic        game_over;

  int tests = 0;
  int fails = 0;

  obstacle_runner dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .start     (start),
    .jump_h    (jump_h),
    .obs_x     (obs_x),
    .score     (score),
    .lives     (lives),
    .hit       (hit),
    .running   (running),
    .game_over (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural game model: mode name, obstacle position, score, lives, recovery ticks left.
  string m_mode;
  int    m_x;
  int    m_score;
  int    m_lives;
  int    m_left;
  int    m_hit;

  task automatic m_reset();
    m_mode  = "IDLE";
    m_x     = 640;
    m_score = 0;
    m_lives = 3;
    m_left  = 0;
    m_hit   = 0;
  endtask

  // One clock of the game rules, given the inputs presented at that edge.
  task automatic m_step(input bit t, input bit s, input int jh);
    int ovl_l;
    int ovl_r;
    bit overlap;
    m_hit = 0;
    if (m_mode == "IDLE") begin
      if (s) m_mode = "RUN";
    end else if (m_mode == "RUN") begin
      if (t) begin
        // Obstacle spans [x, x+20), player spans [100, 120); they touch when the intervals intersect.
        ovl_l   = (m_x > 100) ? m_x : 100;
        ovl_r   = (m_x + 20 < 120) ? m_x + 20 : 120;
        overlap = ovl_l < ovl_r;
        if (overlap && jh < 40) begin
          m_hit   = 1;
          m_lives = m_lives - 1;
          m_x     = 640;
          if (m_lives == 0) m_mode = "OVER";
          else begin
            m_mode = "RECOVER";
            m_left = 16;
          end
        end else if (m_x - 10 < 0) begin
          m_x     = 640;
          m_score = (m_score + 1 > 65535) ? 65535 : m_score + 1;
        end else begin
          m_x = m_x - 10;
        end
      end
    end else if (m_mode == "RECOVER") begin
      if (t) begin
        m_left = m_left - 1;
        if (m_left == 0) m_mode = "RUN";
      end
    end else begin
      if (s) begin
        m_reset();
        m_mode = "RUN";
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".obs_x"}, 32'(obs_x), m_x);
    chk({tag, ".score"}, 32'(score), m_score);
    chk({tag, ".lives"}, 32'(lives), m_lives);
    chk({tag, ".hit"}, 32'(hit), m_hit);
    chk({tag, ".running"}, 32'(running), (m_mode == "RUN" || m_mode == "RECOVER") ? 1 : 0);
    chk({tag, ".game_over"}, 32'(game_over), (m_mode == "OVER") ? 1 : 0);
  endtask

  // Present inputs for one edge, advance the model, sample 1 ns after the edge.
  task automatic cyc(input bit t, input bit s, input int jh);
    tick   = t;
    start  = s;
    jump_h = 10'(jh);
    m_step(t, s, jh);
    @(posedge clk);
    #1;
    tick  = 1'b0;
    start = 1'b0;
  endtask

  // Tick with the given height until the model obstacle reaches x, bounded.
  task automatic run_to(input int x, input int jh, input string tag);
    int n = 0;
    while (m_x != x && n < 200) begin
      cyc(1, 0, jh);
      check_all(tag);
      n++;
    end
    chk({tag, ".reached"}, 32'(obs_x), x);
  endtask

  initial begin
    reset  = 1'b1;
    tick   = 1'b0;
    start  = 1'b0;
    jump_h = '0;
    m_reset();

    // Asynchronous reset at power-up, released between clock edges.
    #2 reset = 1'b0;
    #1;
    check_all("por");
    #5 reset = 1'b1;
    @(posedge clk);
    #1;
    check_all("idle");

    // start and tick together in IDLE: running, but no movement until the next tick.
    cyc(1, 1, 0);
    check_all("st_tick");
    chk("st_tick.x_const", 32'(obs_x), 640);
    cyc(1, 0, 100);
    check_all("st_tick.next");
    chk("st_tick.next_const", 32'(obs_x), 630);

    // Play on to score 5 at x=300, then hit reset mid-cycle.
    begin
      int n = 0;
      while (!(m_score == 5 && m_x == 300) && n < 400) begin
        cyc(1, 0, 100);
        check_all("to300");
        n++;
      end
    end
    chk("pre_rst.x", 32'(obs_x), 300);
    chk("pre_rst.score", 32'(score), 5);
    #2 reset = 1'b0;
    #1;
    m_reset();
    chk("rst.x", 32'(obs_x), 640);
    chk("rst.score", 32'(score), 0);
    chk("rst.lives", 32'(lives), 3);
    chk("rst.flags", {29'd0, hit, running, game_over}, 0);
    #3 reset = 1'b1;
    cyc(1, 0, 0);
    check_all("rst.idle");

    // Clean run: 64 steps down to 0, wrap on tick 65.
    cyc(0, 1, 100);
    check_all("clean.start");
    for (int k = 1; k <= 65; k++) begin
      cyc(1, 0, 100);
      check_all("clean");
      chk("clean.x_const", 32'(obs_x), (k <= 64) ? 640 - 10 * k : 640);
    end
    chk("clean.score_const", 32'(score), 1);

    // Ground collision at x=110 on tick 54, then 16 ticks of recovery.
    for (int k = 1; k <= 53; k++) begin
      cyc(1, 0, 0);
      check_all("ground");
    end
    chk("ground.x110", 32'(obs_x), 110);
    cyc(1, 0, 0);
    check_all("ground.hit");
    chk("ground.hit_const", 32'(hit), 1);
    chk("ground.lives_const", 32'(lives), 2);
    cyc(0, 0, 0);
    check_all("ground.pulse_end");
    for (int k = 1; k <= 16; k++) begin
      cyc(1, 0, 0);
      check_all("recover");
    end
    cyc(1, 0, 0);
    check_all("resume");
    chk("resume.x_const", 32'(obs_x), 630);

    // Height boundary: 40 clears, 80 is outside the player column, 39 collides.
    run_to(110, 0, "b40.approach");
    cyc(1, 0, 40);
    check_all("b40");
    chk("b40.x_const", 32'(obs_x), 100);
    cyc(1, 0, 100);
    check_all("b40.x90");
    cyc(1, 0, 100);
    check_all("b40.x80");
    cyc(1, 0, 0);
    check_all("edge80");
    chk("edge80.hit_const", 32'(hit), 0);
    run_to(110, 100, "b39.approach");
    cyc(1, 0, 39);
    check_all("b39");
    chk("b39.hit_const", 32'(hit), 1);
    for (int k = 1; k <= 16; k++) begin
      cyc(1, 0, 0);
      check_all("recover2");
    end

    // Third collision ends the game; OVER ignores ticks until start.
    run_to(110, 0, "over.approach");
    cyc(1, 0, 0);
    check_all("over.hit");
    chk("over.go_const", 32'(game_over), 1);
    chk("over.lives_const", 32'(lives), 0);
    for (int k = 1; k <= 20; k++) begin
      cyc(1, 0, 0);
      check_all("over.frozen");
    end
    cyc(0, 1, 0);
    check_all("restart");
    chk("restart.lives_const", 32'(lives), 3);
    chk("restart.score_const", 32'(score), 0);
    chk("restart.run_const", 32'(running), 1);

    // Randomized play including boundary heights and stray start pulses.
    for (int k = 0; k < 3000; k++) begin
      int sel;
      int jh;
      sel = $urandom_range(0, 3);
      case (sel)
        0:       jh = 0;
        1:       jh = 39;
        2:       jh = 40;
        default: jh = $urandom_range(0, 1023);
      endcase
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0, jh);
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/obstacle_runner.md
# obstacle_runner

Consumes the player's vertical jump offset produced by the jump generator and closes the loop on gameplay. It scrolls one obstacle horizontally toward the fixed player column on each game tick, detects collisions against the current jump height, tracks lives and score, and sequences idle, run, recover and game-over states. It sits between the jump generator and the VGA draw logic. The draw logic reads `obs_x`, `score`, `lives` and the status flags.

## Interface
- `X_START`, 640: obstacle x position at spawn and after each wrap or hit.
- `SPEED`, 10: pixels moved per tick.
- `PLAYER_X`, 100: left edge of the player column.
- `PLAYER_W`, 20: player width in pixels.
- `OBS_W`, 20: obstacle width in pixels.
- `OBS_H`, 40: obstacle height. The player clears the obstacle when `jump_h >= OBS_H`.
- `LIVES`, 3: starting lives, range 1..3.
- `RECOVER_TICKS`, 16: ticks spent in RECOVER after a non-fatal hit.

Ports (name, direction, width, meaning):
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `tick`, in, 1: one-cycle game-step enable.
- `start`, in, 1: begin or restart a game.
- `jump_h`, in, 10: player height offset from the jump generator, unsigned.
- `obs_x`, out, 10: current obstacle left edge.
- `score`, out, 16: obstacles cleared, saturating.
- `lives`, out, 2: remaining lives.
- `hit`, out, 1: one-cycle pulse on collision.
- `running`, out, 1: high in RUN and RECOVER.
- `game_over`, out, 1: high in OVER.

## Operation
- **States:** IDLE, RUN, RECOVER, OVER.
- **Reset values** (`reset`=0, takes effect immediately, any state):
  - state IDLE
  - `obs_x`=X_START, `score`=0, `lives`=LIVES
  - `hit`=0, `running`=0, `game_over`=0
  - recover counter 0
- **IDLE**
  - Outputs hold reset values.
  - `start`=1 goes to RUN.
  - A `tick` in the same cycle as `start` is not applied.
- **RUN**, on each `tick`, evaluated on pre-update `obs_x`:
  - Collision when all three hold:
    - `obs_x < PLAYER_X+PLAYER_W`
    - `obs_x+OBS_W > PLAYER_X`
    - `jump_h < OBS_H`
  - Compute the x sums in 11 bits. They must not overflow.
  - On collision:
    - `hit` pulses.
    - `lives` decrements.
    - `obs_x` is set to X_START.
    - If `lives` was 1, go to OVER.
    - Otherwise go to RECOVER and load the counter with RECOVER_TICKS.
  - Else if `obs_x < SPEED` (wrap): `obs_x` is set to X_START and `score` increments, saturating at 16'hFFFF.
  - Else: `obs_x` is set to `obs_x - SPEED`. It never underflows.
  - Collision has priority over wrap when both apply on the same tick.
  - `start` is ignored.
- **RECOVER**
  - `obs_x` is held at X_START.
  - No collision checks.
  - Each `tick` decrements the counter.
  - On the tick that takes the counter from 1 to 0, go to RUN. Movement resumes on the next tick.
  - `start` is ignored.
- **OVER**
  - `game_over`=1, `lives`=0.
  - `obs_x` and `score` are frozen.
  - `tick` is ignored.
  - `start`=1 reinitialises `obs_x`, `score`, `lives` and the recover counter to reset values and goes directly to RUN.
- `jump_h` is sampled only on tick cycles. It needs no synchroniser (same clock domain).
- When `tick` is low, nothing changes except the handling of `start`.

## Timing
- All outputs are registered. They update on the rising `clk` edge that samples `tick` or `start` high.
- `hit` is high for exactly one clock, starting the cycle after the colliding tick edge.
- `running` and `game_over` follow the state register with zero added latency.
- Latency from `start` in IDLE or OVER to `running`=1 is one clock.
- Reset deassertion needs no tick. The first `start` after deassertion is honoured.

## Test plan
1. **Reset:** hold `reset`=0 mid-RUN with `obs_x`=300 and `score`=5. Required: immediately `obs_x`=640, `score`=0, `lives`=3, all flags 0. After release: IDLE.
2. **Clean run:** `start`, then `jump_h`=100 constant for 65 ticks. Required:
   - `obs_x` steps 640, 630, … 0 (0 after tick 64).
   - Tick 65 wraps `obs_x` to 640 with `score`=1.
   - `hit` never asserts.
3. **Ground collision:** `jump_h`=0. Required:
   - After 53 ticks, `obs_x`=110.
   - Tick 54 gives a `hit` pulse, `lives`=2, `obs_x`=640, state RECOVER.
   - After 16 more ticks, back in RUN. The next tick gives `obs_x`=630.
4. **Height boundary:** at `obs_x`=110 on the next tick:
   - `jump_h`=40: no hit, `obs_x`=100.
   - Repeat the run with `jump_h`=39: hit.
   - Also, `obs_x`=80 with `jump_h`=0 gives no hit (right edge 100 is not greater than PLAYER_X).
5. **Game over:** three collisions. Required:
   - Third `hit` leads to `game_over`=1, `lives`=0.
   - 20 further ticks leave `obs_x` and `score` unchanged.
   - `start` gives RUN, `lives`=3, `score`=0, `obs_x`=640 the next cycle.
6. **Simultaneous start and tick:** in IDLE, `start` and `tick` in the same cycle. Required: `running`=1, `obs_x` stays 640. The next tick gives `obs_x`=630.
